inst_prefetch_queue: RTL

Fetch-side buffer directly upstream of the 5-stage core. It issues sequential instruction-memory reads, buffers returned words with their PCs in a small FIFO, and presents one instruction per cycle to the core's IF/ID input. It absorbs core stalls (load-use NOP hold, halt) and discards wrong-path words on a branch redirect (flush).

---
 rtl/inst_prefetch_queue_if.sv | 24 ++
 rtl/inst_prefetch_queue.sv | 115 +++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue_if.sv
// Fetch-side bundle: instruction-memory request/response, IF/ID delivery and core control.
// master = prefetch queue side, slave = memory/core side.
interface inst_prefetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc, halt
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetch FIFO feeding the core's IF/ID input (stall, flush-on-redirect, halt).
// Define IFQ_BYPASS_EN to let a response reach inst in the same cycle when the queue is empty.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inst_prefetch_queue_if.master bus
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pc_tag_q, pc_tag_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   tag_q  [DEPTH];

    logic rsp_live, accept, head_vld, byp, room, issue_state, issue, push, pop;

    // A response with nothing outstanding belongs to a request lost across reset.
    assign rsp_live = bus.imem_rvalid && (outst_q != '0);
    assign accept   = rsp_live && (discard_q == '0);
    assign head_vld = (count_q != '0);
    assign room     = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W;

`ifdef IFQ_BYPASS_EN
    assign byp = accept && !head_vld && !bus.redirect;
`else
    assign byp = 1'b0;
`endif

    // The last stale response of a drain re-enables fetch in the same cycle.
    assign issue_state = (state_q == S_RUN) ||
                         ((state_q == S_DRAIN) && rsp_live && (discard_q == ONE));
    assign issue = rst_n && issue_state && room && !bus.redirect && !bus.halt;
    assign pop   = head_vld && bus.inst_ready;
    assign push  = accept && !(byp && bus.inst_ready);

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = head_vld || byp;
    assign bus.inst       = head_vld ? word_q[rd_ptr_q] : (byp ? bus.imem_rdata : NOP_INST);
    assign bus.inst_pc    = head_vld ? tag_q[rd_ptr_q]  : (byp ? pc_tag_q : 32'h0);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_tag_d   = pc_tag_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        outst_d    = outst_q + (issue ? ONE : '0) - (rsp_live ? ONE : '0);
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            pc_tag_d   = bus.redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = outst_d;
            state_d    = (outst_d != '0) ? S_DRAIN : S_RUN;
        end else begin
            if (issue)                          fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_live && discard_q != '0)    discard_d  = discard_q - ONE;
            if (accept)                         pc_tag_d   = pc_tag_q + 32'd4;
            if (push)                           wr_ptr_d   = wr_ptr_q + 1'b1;
            if (pop)                            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d = count_q + (push ? ONE : '0) - (pop ? ONE : '0);
            if (state_q == S_DRAIN && discard_d == '0) state_d = S_RUN;
        end
        if (bus.halt || state_q == S_HALT) state_d = S_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC;
            pc_tag_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_tag_q   <= pc_tag_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: entries are only read while count_q covers them.
    always_ff @(posedge clk) begin
        if (push && !bus.redirect) begin
            word_q[wr_ptr_q] <= bus.imem_rdata;
            tag_q[wr_ptr_q]  <= pc_tag_q;
        end
    end
endmodule
